// File: rtl/c432_key_loader.sv
// Serial key loader for the locked c432 netlist: shifts a key frame into a shadow
// register and releases it only after CHECK. Optional parity check: C432_KEY_PARITY_CHECK_EN.
module c432_key_loader (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       sin_bit,
    input  logic       sin_valid,
    output logic       sin_ready,
    output logic [3:0] key_p,
    output logic [5:0] key_x,
    output logic       key_valid,
    output logic       key_err,
    output logic       lockout,
    output logic       busy
);

`ifdef C432_KEY_PARITY_CHECK_EN
    localparam int FRAME_LEN = 12;
`else
    localparam int FRAME_LEN = 10;
`endif
    localparam logic [3:0] LAST_BIT = 4'(FRAME_LEN - 1);

    typedef enum logic [2:0] {IDLE, SHIFT, CHECK, DONE, ERR, LOCK} state_t;

    state_t               r_state;
    state_t               w_next;
    logic [3:0]           r_bit_cnt;
    logic [FRAME_LEN-1:0] r_shadow;
    logic                 w_xfer;
    logic                 w_last;
    logic                 w_restart;
    logic                 w_pass;
    logic                 w_fail_lock;

    // A start pulse wins over a simultaneous bit, so nothing is counted that cycle.
    assign w_xfer    = (r_state == SHIFT) && sin_valid && !start;
    assign w_last    = w_xfer && (r_bit_cnt == LAST_BIT);
    assign w_restart = start && (r_state == IDLE || r_state == SHIFT ||
                                 r_state == DONE || r_state == ERR);

`ifdef C432_KEY_PARITY_CHECK_EN
    logic [1:0] r_fail_cnt;

    assign w_pass      = ((^r_shadow[3:0]) == r_shadow[10]) &&
                         ((^r_shadow[9:4]) == r_shadow[11]);
    assign w_fail_lock = (r_fail_cnt == 2'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fail_cnt <= 2'd0;
        end else if (r_state == CHECK) begin
            if (w_pass)
                r_fail_cnt <= 2'd0;
            else if (r_fail_cnt != 2'd3)
                r_fail_cnt <= r_fail_cnt + 2'd1;
        end
    end
`else
    assign w_pass      = 1'b1;
    assign w_fail_lock = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (start) w_next = SHIFT;
            SHIFT: begin
                if (start)
                    w_next = SHIFT;
                else if (w_last)
                    w_next = CHECK;
            end
            CHECK: begin
                if (w_pass)
                    w_next = DONE;
                else if (w_fail_lock)
                    w_next = LOCK;
                else
                    w_next = ERR;
            end
            DONE:  if (start) w_next = SHIFT;
            ERR:   if (start) w_next = SHIFT;
            LOCK:  w_next = LOCK;
            default: w_next = IDLE;
        endcase
    end

    // First bit received ends up in bit 0 once the whole frame has been shifted in.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt <= 4'd0;
            r_shadow  <= '0;
        end else if (w_restart) begin
            r_bit_cnt <= 4'd0;
            r_shadow  <= '0;
        end else if (w_xfer) begin
            r_bit_cnt <= r_bit_cnt + 4'd1;
            r_shadow  <= {sin_bit, r_shadow[FRAME_LEN-1:1]};
        end
    end

    always_comb begin
        sin_ready = 1'b0;
        busy      = 1'b0;
        key_valid = 1'b0;
        key_err   = 1'b0;
        lockout   = 1'b0;
        key_p     = 4'd0;
        key_x     = 6'd0;
        case (r_state)
            SHIFT: begin
                sin_ready = 1'b1;
                busy      = 1'b1;
            end
            CHECK: busy = 1'b1;
            DONE: begin
                key_valid = 1'b1;
                key_p     = r_shadow[3:0];
                key_x     = r_shadow[9:4];
            end
            ERR: begin
`ifdef C432_KEY_PARITY_CHECK_EN
                key_err = 1'b1;
`endif
            end
            LOCK: begin
`ifdef C432_KEY_PARITY_CHECK_EN
                key_err = 1'b1;
                lockout = 1'b1;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_c432_key_loader.sv
// Bench for c432_key_loader: vector table, hand-written corner sequences and
// randomized frames checked against a frame-level reference model.
module tb_c432_key_loader;

`ifdef C432_KEY_PARITY_CHECK_EN
    localparam int FLEN = 12;
    localparam bit PAR  = 1'b1;
`else
    localparam int FLEN = 10;
    localparam bit PAR  = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       sin_bit = 1'b0;
    logic       sin_valid = 1'b0;
    logic       sin_ready;
    logic [3:0] key_p;
    logic [5:0] key_x;
    logic       key_valid;
    logic       key_err;
    logic       lockout;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;
    int m_fails = 0;

    c432_key_loader dut (
        .clk(clk), .rst(rst), .start(start), .sin_bit(sin_bit), .sin_valid(sin_valid),
        .sin_ready(sin_ready), .key_p(key_p), .key_x(key_x), .key_valid(key_valid),
        .key_err(key_err), .lockout(lockout), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] p;
        logic [5:0] x;
        logic       pp;
        logic       px;
        logic       exp_valid;
        logic       exp_err;
        logic [3:0] exp_p;
        logic [5:0] exp_x;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string nm);
        check({nm, " key_p"}, 32'(key_p), 0);
        check({nm, " key_x"}, 32'(key_x), 0);
        check({nm, " key_valid"}, 32'(key_valid), 0);
        check({nm, " key_err"}, 32'(key_err), 0);
        check({nm, " lockout"}, 32'(lockout), 0);
        check({nm, " busy"}, 32'(busy), 0);
        check({nm, " sin_ready"}, 32'(sin_ready), 0);
    endtask

    task automatic do_reset;
        rst = 1'b1; start = 1'b0; sin_valid = 1'b0; sin_bit = 1'b0;
        tick;
        rst = 1'b0;
        m_fails = 0;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        check("sin_ready in shift", 32'(sin_ready), 1);
        sin_valid = 1'b1;
        sin_bit   = b;
        tick;
        sin_valid = 1'b0;
        sin_bit   = 1'($urandom);
    endtask

    task automatic send_frame(input logic [3:0] p, input logic [5:0] x, input logic pp,
                              input logic px, input int gap_at, input int gap_len);
        logic [11:0] bits;
        bits = {px, pp, x, p};
        for (int i = 0; i < FLEN; i++) begin
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    sin_bit = 1'($urandom);
                    tick;
                    check("busy during gap", 32'(busy), 1);
                end
            end
            send_bit(bits[i]);
        end
    endtask

    // Called in the CHECK cycle right after the last transfer.
    task automatic expect_result(input string nm, input logic [3:0] p, input logic [5:0] x,
                                 input logic pp, input logic px);
        logic pass;
        logic lock;
        pass = !PAR || (((^p) == pp) && ((^x) == px));
        if (pass) m_fails = 0;
        else      m_fails++;
        lock = (m_fails >= 3);
        check({nm, " check busy"}, 32'(busy), 1);
        check({nm, " check key_valid"}, 32'(key_valid), 0);
        check({nm, " check key_p"}, 32'(key_p), 0);
        tick;
        check({nm, " key_valid"}, 32'(key_valid), 32'(pass));
        check({nm, " key_err"}, 32'(key_err), 32'(!pass));
        check({nm, " lockout"}, 32'(lockout), 32'(lock));
        check({nm, " key_p"}, 32'(key_p), pass ? 32'(p) : 0);
        check({nm, " key_x"}, 32'(key_x), pass ? 32'(x) : 0);
        check({nm, " busy"}, 32'(busy), 0);
        check({nm, " sin_ready"}, 32'(sin_ready), 0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{4'h5, 6'h33, 1'b0, 1'b0, 1'b1, 1'b0, 4'h5, 6'h33};
        tbl[1] = '{4'hF, 6'h3F, 1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 6'h3F};
        tbl[2] = '{4'h1, 6'h01, 1'b1, 1'b1, 1'b1, 1'b0, 4'h1, 6'h01};
        tbl[3] = '{4'h0, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 6'h00};
        tbl[4] = '{4'h8, 6'h20, 1'b1, 1'b1, 1'b1, 1'b0, 4'h8, 6'h20};
        tbl[5] = '{4'h6, 6'h15, 1'b0, 1'b1, 1'b1, 1'b0, 4'h6, 6'h15};

        @(negedge clk);
        do_reset;
        check_idle_outputs("reset");

        // sin_valid while idle must not move the block
        sin_valid = 1'b1; sin_bit = 1'b1;
        tick; tick; tick;
        sin_valid = 1'b0;
        check_idle_outputs("idle sin_valid");

        for (int i = 0; i < 6; i++) begin
            pulse_start;
            send_frame(tbl[i].p, tbl[i].x, tbl[i].pp, tbl[i].px, FLEN, 0);
            check("tbl check-cycle busy", 32'(busy), 1);
            tick;
            check("tbl key_valid", 32'(key_valid), 32'(tbl[i].exp_valid));
            check("tbl key_err", 32'(key_err), 32'(tbl[i].exp_err));
            check("tbl key_p", 32'(key_p), 32'(tbl[i].exp_p));
            check("tbl key_x", 32'(key_x), 32'(tbl[i].exp_x));
            m_fails = 0;
        end

        // start in DONE drops the key on the next cycle
        pulse_start;
        check("done restart key_valid", 32'(key_valid), 0);
        check("done restart key_p", 32'(key_p), 0);
        check("done restart key_x", 32'(key_x), 0);
        check("done restart busy", 32'(busy), 1);

        // restart after 5 bits: only the second frame counts
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        pulse_start;
        send_frame(4'h6, 6'h15, 1'b0, 1'b1, FLEN, 0);
        expect_result("restart", 4'h6, 6'h15, 1'b0, 1'b1);

        // start together with a valid bit counts no transfer
        start = 1'b1; sin_valid = 1'b1; sin_bit = 1'b1;
        tick;
        start = 1'b0; sin_valid = 1'b0;
        check("start+valid lands in shift", 32'(sin_ready), 1);
        start = 1'b1; sin_valid = 1'b1; sin_bit = 1'b1;
        tick;
        start = 1'b0; sin_valid = 1'b0;
        send_frame(4'h2, 6'h0C, 1'b1, 1'b0, FLEN, 0);
        expect_result("start+valid", 4'h2, 6'h0C, 1'b1, 1'b0);

        // long stall mid-frame
        pulse_start;
        send_frame(4'h5, 6'h33, 1'b0, 1'b0, 5, 20);
        expect_result("stall", 4'h5, 6'h33, 1'b0, 1'b0);

        // rst while in DONE
        rst = 1'b1;
        tick;
        rst = 1'b0;
        m_fails = 0;
        check_idle_outputs("rst in done");
        sin_valid = 1'b1;
        tick;
        sin_valid = 1'b0;
        check("after rst still idle", 32'(busy), 0);

`ifdef C432_KEY_PARITY_CHECK_EN
        // single bad frame, then recovery from ERR
        pulse_start;
        send_frame(4'h5, 6'h33, 1'b0, 1'b1, FLEN, 0);
        expect_result("bad px", 4'h5, 6'h33, 1'b0, 1'b1);
        pulse_start;
        check("err restart key_err", 32'(key_err), 0);
        check("err restart busy", 32'(busy), 1);
        send_frame(4'h3, 6'h07, 1'b1, 1'b0, FLEN, 0);
        expect_result("bad pp", 4'h3, 6'h07, 1'b1, 1'b0);
        // a pass clears the failure run
        pulse_start;
        send_frame(4'h5, 6'h33, 1'b0, 1'b0, FLEN, 0);
        expect_result("good clears", 4'h5, 6'h33, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            pulse_start;
            send_frame(4'h9, 6'h11, 1'b1, 1'b1, FLEN, 0);
            expect_result("bad run", 4'h9, 6'h11, 1'b1, 1'b1);
        end
        check("locked lockout", 32'(lockout), 1);
        pulse_start;
        check("lock ignores start ready", 32'(sin_ready), 0);
        check("lock ignores start busy", 32'(busy), 0);
        sin_valid = 1'b1;
        for (int i = 0; i < FLEN + 2; i++) begin
            sin_bit = 1'($urandom);
            tick;
        end
        sin_valid = 1'b0;
        check("lock held lockout", 32'(lockout), 1);
        check("lock held key_err", 32'(key_err), 1);
        check("lock held key_valid", 32'(key_valid), 0);
        check("lock held key_p", 32'(key_p), 0);
        check("lock held key_x", 32'(key_x), 0);
        do_reset;
        check_idle_outputs("rst clears lock");
`endif

        // randomized frames against the model
        for (int it = 0; it < 60; it++) begin
            logic [3:0] p;
            logic [5:0] x;
            logic       pp;
            logic       px;
            if ($urandom_range(0, 4) == 0) begin
                int nb;
                pulse_start;
                nb = int'($urandom_range(1, FLEN - 1));
                for (int i = 0; i < nb; i++) send_bit(1'($urandom));
            end
            pulse_start;
            p  = 4'($urandom);
            x  = 6'($urandom);
            pp = (^p) ^ ($urandom_range(0, 3) == 0);
            px = (^x) ^ ($urandom_range(0, 3) == 0);
            send_frame(p, x, pp, px, int'($urandom_range(0, FLEN - 1)),
                       int'($urandom_range(0, 3)));
            expect_result("random", p, x, pp, px);
            if (m_fails >= 3) do_reset;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/c432_key_loader.md
C432_KEY_LOADER -- requirements
Module: c432_key_loader

Interface
REQ-001 The interface SHALL have one clock and a synchronous, active-high reset; `clk` and `rst` are listed first below.
REQ-002 clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  single-cycle pulse that begins a key load.
REQ-005 sin_bit  input  1  serial key frame bit.
REQ-006 sin_valid  input  1  sin_bit is valid this cycle.
REQ-007 sin_ready  output  1  loader accepts a bit this cycle; a transfer occurs when sin_valid and sin_ready are both 1.
REQ-008 key_p  output  4  MUX4 select key, p1..p4 on bits [0..3], driving the locked c432 netlist.
REQ-009 key_x  output  6  XOR key, X_1..X_6 on bits [0..5], driving the locked c432 netlist.
REQ-010 key_valid  output  1  key outputs hold an accepted key.
REQ-011 key_err  output  1  last frame failed its check.
REQ-012 lockout  output  1  three consecutive failed loads; cleared only by reset.
REQ-013 busy  output  1  a load is in progress.

Function
REQ-014 Frame format, in transfer order:
- 4 bits p1..p4, LSB first;
- then 6 bits X_1..X_6;
- then, with the check enabled, parity bit Pp and then parity bit Px.
REQ-015 The FSM SHALL have these states: IDLE, SHIFT, CHECK, DONE, ERR, LOCK.
REQ-016 State transitions:
- IDLE --start--> SHIFT;
- SHIFT --last frame bit transferred--> CHECK;
- CHECK --pass--> DONE;
- CHECK --fail--> ERR, or LOCK when this is the third consecutive failure.
REQ-017 sin_ready SHALL be 1 only in SHIFT.
REQ-018 Bits SHALL shift into an internal shadow register only; a 4-bit bit counter counts transfers and wraps to 0 on entry to SHIFT.
REQ-019 CHECK SHALL last exactly one cycle.
REQ-020 In DONE, the shadow value SHALL be copied to key_p/key_x in the same cycle that key_valid rises, so key_valid rises two cycles after the last transfer.
REQ-021 key_p/key_x SHALL be 0 in every state except DONE; a wrong or partial key never reaches the netlist.
REQ-022 key_err SHALL be 1 in ERR and LOCK only.
REQ-023 The consecutive-failure counter (2 bits) SHALL increment on each failed CHECK and clear on a passed CHECK.
REQ-024 start in SHIFT SHALL restart the load: counter to 0, shadow register cleared, no transfer counted that cycle.
REQ-025 start in DONE or ERR SHALL drop key_valid/key_err and zero the key outputs the next cycle, and enter SHIFT.
REQ-026 LOCK SHALL ignore start and sin_valid, and hold lockout=1, key_err=1, key outputs 0 until rst.
REQ-027 sin_valid outside SHIFT SHALL be ignored with no state change.
REQ-028 busy SHALL be 1 in SHIFT and CHECK.

Reset
REQ-029 On rst, the block SHALL enter IDLE in the next cycle with:
- key_p = 0, key_x = 0;
- key_valid, key_err, lockout, busy, sin_ready all 0;
- failure counter, bit counter and shadow register all 0.
REQ-030 rst SHALL override every other input, including during SHIFT and in LOCK.

Configuration
REQ-031 Macro C432_KEY_PARITY_CHECK_EN controls the parity check.
REQ-032 With C432_KEY_PARITY_CHECK_EN defined:
- the frame is 12 bits;
- CHECK passes iff (XOR of p1..p4) XOR Pp = 0 and (XOR of X_1..X_6) XOR Px = 0;
- the failure counter and LOCK are present.
REQ-033 With C432_KEY_PARITY_CHECK_EN undefined:
- the frame is 10 bits and CHECK always passes;
- ERR and LOCK are unreachable;
- key_err and lockout are tied to 0.

Verification
REQ-034 (check enabled) rst; start; send p=1010, x=110011, Pp=0, Px=0 -> key_valid=1 two cycles after the last bit, key_p=4'b0101 (p1=1, p2=0, p3=1, p4=0 on bits [0..3]), key_x=6'b110011 (X_1..X_6 = 1,1,0,0,1,1 on bits [0..5]), key_err=0.
REQ-035 (check enabled) Same frame with Px=1 -> key_err=1, key_valid=0, key outputs stay 0; failure count = 1.
REQ-036 (check enabled) Three bad frames back-to-back -> lockout=1 after the third CHECK; a following good frame with start is ignored; rst clears lockout.
REQ-037 start after 5 bits accepted, then a full good frame -> key equals the second frame only; the first 5 bits have no effect.
REQ-038 sin_valid held at 0 for 20 cycles mid-frame, then bits resume -> correct key; busy stays 1 throughout.
REQ-039 rst asserted while in DONE -> next cycle key_p=0, key_x=0, key_valid=0, state IDLE.
